// File: rtl/adder32_checker.sv
// adder32_checker: compares an external adder's sum/carry against a golden
// WIDTH+1-bit result after a fixed settle time and keeps pass/fail statistics.
module adder32_checker #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_co,
  input  logic             clr_err,
  output logic             done,
  output logic             pass,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic             err_sticky,
  output logic [WIDTH-1:0] exp_s,
  output logic             exp_co
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic match;
  assign match = (dut_s == exp_s) && (dut_co == exp_co);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (in_valid ? WAIT : IDLE) :
               state == WAIT ? (cnt == 8'd1 ? CHECK : WAIT) : IDLE;
  always_comb in_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt        <= '0;
      exp_s      <= '0;
      exp_co     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      done <= state == CHECK;
      if (in_ready && in_valid) begin
        cnt             <= 8'(SETTLE);
        {exp_co, exp_s} <= {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
      end else if (state == WAIT) cnt <= cnt - 8'd1;
      if (state == CHECK) begin
        pass <= match;
        if (match && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        if (!match && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      end
      // a mismatch at the same edge as a clear request leaves the flag set
      err_sticky <= (state == CHECK && !match) ? 1'b1 : clr_err ? 1'b0 : err_sticky;
    end
endmodule

// File: tb/tb_adder32_checker.sv
// tb_adder32_checker: randomized and directed checks of adder32_checker
// against a plain-arithmetic reference model.
module tb_adder32_checker;
  localparam int W  = 32;
  localparam int ST = 4;
  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ci = 1'b0;
  logic         dut_co = 1'b0, clr_err = 1'b0;
  logic [W-1:0] a = '0, b = '0, dut_s = '0;
  logic         in_ready, done, pass, err_sticky, exp_co;
  logic [15:0]  pass_cnt, fail_cnt;
  logic [W-1:0] exp_s;
  int           vecs = 0, errs = 0;
  logic [15:0]  m_pass = 0, m_fail = 0;
  logic         m_err = 1'b0;

  adder32_checker #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .dut_s(dut_s), .dut_co(dut_co), .clr_err(clr_err),
    .done(done), .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_sticky(err_sticky), .exp_s(exp_s), .exp_co(exp_co));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] gold(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [63:0] t;
    t = 64'(x) + 64'(y) + 64'(c);
    return t[W:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    vecs++;
    if ({in_ready, done, pass, err_sticky, exp_co} !== 5'b10000 || pass_cnt !== 16'd0 ||
        fail_cnt !== 16'd0 || exp_s !== '0) begin
      errs++;
      $display("FAIL %s: rdy=%b done=%b pass=%b err=%b co=%b pc=%h fc=%h s=%h, want rdy=1 and all else 0",
               tag, in_ready, done, pass, err_sticky, exp_co, pass_cnt, fail_cnt, exp_s);
    end
  endtask

  // One full transaction; called #1 after a rising edge with the checker idle.
  task automatic run_vec(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic [W-1:0] s, input logic co, input logic clr);
    logic [W:0] g;
    logic ok;
    int n;
    g  = gold(x, y, c);
    ok = ({co, s} == g);
    a = x; b = y; ci = c; dut_s = s; dut_co = co; clr_err = clr; in_valid = 1'b1;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL %s ready: got %b want 1", tag, in_ready); end
    tick;
    in_valid = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom);
    vecs++;
    if ({exp_co, exp_s} !== g) begin errs++; $display("FAIL %s golden: got %h want %h", tag, {exp_co, exp_s}, g); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin tick; n++; end
    vecs++;
    if (n != ST + 1) begin errs++; $display("FAIL %s latency: got %0d edges want %0d", tag, n, ST + 1); end
    if (ok) m_pass = (m_pass == 16'hFFFF) ? m_pass : m_pass + 16'd1;
    else    m_fail = (m_fail == 16'hFFFF) ? m_fail : m_fail + 16'd1;
    m_err = !ok ? 1'b1 : clr ? 1'b0 : m_err;
    vecs++;
    if (pass !== ok || pass_cnt !== m_pass || fail_cnt !== m_fail || err_sticky !== m_err ||
        {exp_co, exp_s} !== g) begin
      errs++;
      $display("FAIL %s result: pass=%b pc=%h fc=%h err=%b exp=%h want pass=%b pc=%h fc=%h err=%b exp=%h",
               tag, pass, pass_cnt, fail_cnt, err_sticky, {exp_co, exp_s}, ok, m_pass, m_fail, m_err, g);
    end
    clr_err = 1'b0;
    tick;
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL %s done pulse width: got %b want 0", tag, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_vec("basic", 32'd5, 32'd10, 1'b1, 32'd16, 1'b0, 1'b0);
  endtask

  task automatic test_mismatch_clear;
    run_vec("mismatch", 32'd37, 32'd48, 1'b0, 32'd84, 1'b0, 1'b0);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    vecs++;
    if (err_sticky !== 1'b0 || fail_cnt !== m_fail) begin
      errs++;
      $display("FAIL clr_err: err=%b fc=%h want err=0 fc=%h", err_sticky, fail_cnt, m_fail);
    end
    m_err = 1'b0;
    run_vec("clr_vs_set", 32'd37, 32'd48, 1'b0, 32'd84, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    run_vec("ovf_match", '1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    run_vec("ovf_miss", '1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic c, flip;
    logic [W:0] g;
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom);
      g = gold(x, y, c);
      flip = 1'($urandom);
      if (flip) g = g ^ ((W+1)'(1) << $urandom_range(W, 0));
      run_vec("random", x, y, c, g[W-1:0], g[W], 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va [9];
    logic [W-1:0] vb [9];
    logic [W:0] g;
    logic rdy;
    int k, cyc, last, dones, n;
    va = '{32'd5, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd100, 32'd127};
    vb = '{32'd10, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd27, 32'd127};
    k = 0; cyc = 0; last = -1; dones = 0;
    in_valid = 1'b1;
    while (k < 9 && cyc < 200) begin
      rdy = in_ready;
      if (rdy) begin a = va[k]; b = vb[k]; ci = 1'b1; end
      else begin a = $urandom; b = $urandom; ci = 1'($urandom); end
      tick;
      cyc++;
      if (done) dones++;
      if (rdy) begin
        if (last >= 0) begin
          vecs++;
          if (cyc - last != ST + 2) begin
            errs++;
            $display("FAIL b2b interval: got %0d cycles want %0d", cyc - last, ST + 2);
          end
        end
        last = cyc;
        g = gold(va[k], vb[k], 1'b1);
        {dut_co, dut_s} = g;
        vecs++;
        if ({exp_co, exp_s} !== g) begin errs++; $display("FAIL b2b golden: got %h want %h", {exp_co, exp_s}, g); end
        k++;
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (dones < 9 && n < 20) begin tick; n++; if (done) dones++; end
    m_pass = m_pass + 16'd9;
    vecs++;
    if (k != 9 || dones != 9 || pass_cnt !== m_pass || fail_cnt !== m_fail) begin
      errs++;
      $display("FAIL b2b totals: accepted=%0d dones=%0d pc=%h fc=%h want 9 9 pc=%h fc=%h",
               k, dones, pass_cnt, fail_cnt, m_pass, m_fail);
    end
    tick;
  endtask

  task automatic test_reset_abort;
    a = 32'd1; b = 32'd2; ci = 1'b0; dut_s = 32'd3; dut_co = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check_reset_vals("abort_async");
    tick;
    check_reset_vals("abort_held");
    m_pass = 0; m_fail = 0; m_err = 1'b0;
    rst = 1'b0;
    run_vec("first_after_rst", 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 1'b0);
  endtask

  task automatic test_saturation;
    force dut.fail_cnt = 16'hFFFD;
    #1;
    release dut.fail_cnt;
    m_fail = 16'hFFFD;
    for (int i = 0; i < 3; i++)
      run_vec("saturate", 32'd37, 32'd48, 1'b0, 32'd84, 1'b0, 1'b0);
    vecs++;
    if (fail_cnt !== 16'hFFFF) begin errs++; $display("FAIL saturate final: got %h want ffff", fail_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mismatch_clear;
    test_overflow;
    test_random;
    test_back_to_back;
    test_reset_abort;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/adder32_checker.md
ADDER32_CHECKER -- requirements
Module: adder32_checker

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and sum width.
REQ-002 Parameter SETTLE, default 4, SHALL set the number of WAIT cycles allowed for the DUT to settle; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate a new stimulus vector on a, b and ci.
REQ-006 in_ready  output  1  SHALL indicate that the checker accepts a vector this cycle.
REQ-007 a, b  input  WIDTH each  SHALL be the operands applied to the adder under test.
REQ-008 ci  input  1  SHALL be the carry-in applied to the adder under test.
REQ-009 dut_s  input  WIDTH  SHALL be the sum returned by the adder under test.
REQ-010 dut_co  input  1  SHALL be the carry-out returned by the adder under test.
REQ-011 clr_err  input  1  SHALL be a synchronous request to clear err_sticky.
REQ-012 done  output  1  SHALL be a one-cycle pulse marking a completed check.
REQ-013 pass  output  1  SHALL be the result of the latest check (1 = match), held until the next check.
REQ-014 pass_cnt, fail_cnt  output  16 each  SHALL count matching and mismatching checks.
REQ-015 err_sticky  output  1  SHALL flag that at least one mismatch has occurred.
REQ-016 exp_s  output  WIDTH  and  exp_co  output  1  SHALL hold the golden result of the latest accepted vector.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and CHECK; in_ready SHALL equal (state == IDLE).
REQ-018 In IDLE, when in_valid=1 at an edge, the checker SHALL latch a, b and ci, load the wait counter with SETTLE and enter WAIT; when in_valid=0 it SHALL stay in IDLE.
REQ-019 The golden result SHALL be {exp_co, exp_s} = a + b + ci, computed at WIDTH+1 bits with no truncation; it SHALL be registered at the accepting edge.
REQ-020 In WAIT, the counter SHALL decrement once per edge; at the edge where it equals 1 the FSM SHALL enter CHECK.
REQ-021 In CHECK, a match SHALL be (dut_s == exp_s) && (dut_co == exp_co), sampled at the edge that leaves CHECK.
REQ-022 At the edge leaving CHECK, the checker SHALL update the outputs as follows:
- done SHALL be set to 1 for exactly one cycle.
- pass SHALL be set to the match result.
- On a match, pass_cnt SHALL increment; otherwise fail_cnt SHALL increment.
- The FSM SHALL return to IDLE.
REQ-023 Latency SHALL be fixed: done SHALL be high in the cycle after the (SETTLE+1)th edge following the accepting edge.
REQ-024 in_valid SHALL be ignored during WAIT and CHECK; no vector is queued.
REQ-025 A new vector SHALL be acceptable in the same cycle in which done is high, giving back-to-back throughput of one check per SETTLE+2 cycles.
REQ-026 pass_cnt and fail_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 err_sticky SHALL be set on any mismatch and cleared only by rst or by clr_err=1 at an edge.
REQ-028 If clr_err=1 coincides with a mismatch at the same edge, err_sticky SHALL end at 1 (set wins).
REQ-029 Operand overflow SHALL be checked exactly; for example, all-ones + 1 + 0 expects exp_s=0 and exp_co=1.

Reset
REQ-030 While rst=1, the checker SHALL hold:
- state = IDLE, so in_ready = 1;
- done = 0 and pass = 0;
- pass_cnt = 0, fail_cnt = 0 and err_sticky = 0;
- exp_s = 0, exp_co = 0 and the wait counter = 0.
REQ-031 Asserting rst during WAIT or CHECK SHALL abort the check immediately, with no done pulse and no counter update.
REQ-032 After rst deasserts, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-033 a=5, b=10, ci=1, dut_s=16, dut_co=0, SETTLE=4 -> done exactly 5 edges after acceptance, pass=1, pass_cnt=1, err_sticky=0.
REQ-034 a=37, b=48, ci=0, dut_s=84 -> exp_s=85, pass=0, fail_cnt=1, err_sticky=1; then clr_err pulse -> err_sticky=0 with fail_cnt still 1.
REQ-035 a=32'hFFFFFFFF, b=1, ci=0, dut_s=0, dut_co=1 -> pass=1; the same vector with dut_co=0 -> pass=0.
REQ-036 Nine back-to-back vectors (5+10+1 through 127+127+1=255) with in_valid held high -> one acceptance every SETTLE+2 cycles, pass_cnt=9, and in_valid ignored while busy.
REQ-037 rst asserted in WAIT -> outputs at reset values within the same cycle, no done pulse; fail_cnt forced to 16'hFFFF by repeated mismatches, then one more mismatch -> fail_cnt remains 16'hFFFF.
